// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC issue controller.
package mac_pkg;
   localparam int   DATA_W   = 16;
   localparam logic MODE_INT = 1'b0;
   localparam logic MODE_FP  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CFG,
      RUN,
      READ,
      WAIT,
      HOLD
   } issue_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } op_pair_t;
endpackage

// File: rtl/mac_issue_ctrl_if.sv
// Job, operand, result and MAC-side signals of the issue controller.
// The slave modport is the controller's view; master is the environment's.
interface mac_issue_ctrl_if #(parameter int LEN_W = 8);
   import mac_pkg::*;

   logic              job_vld;
   logic              job_rdy;
   logic              job_mode;
   logic [LEN_W-1:0]  job_len;
   logic              op_vld;
   logic              op_rdy;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              res_vld;
   logic              res_rdy;
   logic [DATA_W-1:0] res_c;
   logic [DATA_W-1:0] mac_a;
   logic [DATA_W-1:0] mac_b;
   logic              mac_en;
   logic              mac_vld;
   logic              mac_rd;
   logic              mac_mode;
   logic              mac_cfg;
   logic [DATA_W-1:0] mac_c;
   logic              busy;

   modport slave (
      input  job_vld, job_mode, job_len, op_vld, op_a, op_b, res_rdy, mac_c,
      output job_rdy, op_rdy, res_vld, res_c, mac_a, mac_b, mac_en, mac_vld,
             mac_rd, mac_mode, mac_cfg, busy
   );

   modport master (
      output job_vld, job_mode, job_len, op_vld, op_a, op_b, res_rdy, mac_c,
      input  job_rdy, op_rdy, res_vld, res_c, mac_a, mac_b, mac_en, mac_vld,
             mac_rd, mac_mode, mac_cfg, busy
   );
endinterface

// File: rtl/mac_op_fifo.sv
// Synchronous operand FIFO; zero-latency head read, write visible next cycle.
// Push is ignored when full and pop when empty; no bypass of a full FIFO.
module mac_op_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign dout    = mem[rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp      <= wp + AW'(1);
         end
         if (do_pop) rp <= rp + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/mac_issue_ctrl.sv
// Issues one job to the MAC: cfg pulse, operands, read, result after RD_LAT; outputs registered.
// Operands stall (mac_vld low) while the FIFO is empty; the result holds in HOLD until res_rdy.
module mac_issue_ctrl
   import mac_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int RD_LAT = 2,
   parameter int LEN_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   mac_issue_ctrl_if.slave bus
);
   localparam int WC_W = $clog2(RD_LAT + 1);

   issue_state_e      st;
   issue_state_e      nxt;
   logic [LEN_W-1:0]  count;
   logic [LEN_W-1:0]  cnt_n;
   logic [LEN_W-1:0]  len;
   logic [WC_W-1:0]   wcnt;
   logic [WC_W-1:0]   wc_n;
   logic              live;
   logic              accept;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              cap;
   op_pair_t          head;
   logic [DATA_W-1:0] n_a;
   logic [DATA_W-1:0] n_b;
   logic              n_vld;
   logic              n_cfg;
   logic              n_rd;
   logic              n_en;
   logic              n_res_vld;

   // live keeps both ready outputs low until the first cycle after reset
   assign bus.job_rdy = live && (st == IDLE);
   assign bus.op_rdy  = live && !full;
   assign push        = bus.op_vld && bus.op_rdy;
   assign accept      = bus.job_vld && bus.job_rdy;

   mac_op_fifo #(.DEPTH(DEPTH), .WIDTH($bits(op_pair_t))) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({bus.op_a, bus.op_b}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // Outputs are computed for the state being entered and registered with it
   always_comb begin
      nxt       = st;
      cnt_n     = count;
      wc_n      = wcnt;
      pop       = 1'b0;
      cap       = 1'b0;
      n_a       = '0;
      n_b       = '0;
      n_vld     = 1'b0;
      n_cfg     = 1'b0;
      n_rd      = 1'b0;
      n_en      = 1'b0;
      n_res_vld = 1'b0;
      unique case (st)
         IDLE: begin
            if (accept) begin
               nxt   = CFG;
               cnt_n = '0;
               n_cfg = 1'b1;
               n_vld = 1'b1;
               n_en  = 1'b1;
            end
         end
         CFG, RUN: begin
            n_en = 1'b1;
            if (count == len) begin
               nxt  = READ;
               n_rd = 1'b1;
            end else begin
               nxt = RUN;
               if (!empty) begin
                  pop   = 1'b1;
                  n_vld = 1'b1;
                  n_a   = head.a;
                  n_b   = head.b;
                  cnt_n = count + LEN_W'(1);
               end
            end
         end
         READ: begin
            nxt  = WAIT;
            n_en = 1'b1;
            wc_n = WC_W'(1);
         end
         WAIT: begin
            if (wcnt == WC_W'(RD_LAT)) begin
               nxt       = HOLD;
               cap       = 1'b1;
               n_res_vld = 1'b1;
            end else begin
               n_en = 1'b1;
               wc_n = wcnt + WC_W'(1);
            end
         end
         HOLD: begin
            if (bus.res_rdy) nxt = IDLE;
            else             n_res_vld = 1'b1;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st           <= IDLE;
         count        <= '0;
         len          <= '0;
         wcnt         <= '0;
         live         <= 1'b0;
         bus.mac_a    <= '0;
         bus.mac_b    <= '0;
         bus.mac_vld  <= 1'b0;
         bus.mac_cfg  <= 1'b0;
         bus.mac_rd   <= 1'b0;
         bus.mac_en   <= 1'b0;
         bus.mac_mode <= 1'b0;
         bus.res_vld  <= 1'b0;
         bus.res_c    <= '0;
         bus.busy     <= 1'b0;
      end else begin
         st          <= nxt;
         count       <= cnt_n;
         wcnt        <= wc_n;
         live        <= 1'b1;
         bus.mac_a   <= n_a;
         bus.mac_b   <= n_b;
         bus.mac_vld <= n_vld;
         bus.mac_cfg <= n_cfg;
         bus.mac_rd  <= n_rd;
         bus.mac_en  <= n_en;
         bus.res_vld <= n_res_vld;
         bus.busy    <= (nxt != IDLE);
         if (accept) begin
            len          <= bus.job_len;
            bus.mac_mode <= bus.job_mode;
         end
         if (cap) bus.res_c <= bus.mac_c;
      end
   end
endmodule

// File: doc/mac_issue_ctrl.md
# mac_issue_ctrl

Upstream issue controller for the INT/FP MAC core. It accepts a job descriptor (mode and operand count) and a stream of 16-bit operand pairs, and buffers the operands in a small FIFO. For each job it drives the MAC's configure pulse, issues the operands, then issues a read and returns the accumulated result on a valid/ready output. It owns every MAC input (a, b, en, vld, rd, mode, cfg) and consumes the MAC's c.

## Interface
Parameters:
- DEPTH, 4: operand FIFO entries (power of two, ≥2)
- RD_LAT, 2: cycles from mac_rd to valid mac_c (≥1)
- LEN_W, 8: width of job operand count

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- job_vld  in  1  job descriptor valid
- job_rdy  out  1  job accepted when job_vld & job_rdy
- job_mode  in  1  0 = INT16, 1 = FP16
- job_len  in  LEN_W  operand pairs in job (0 allowed)
- op_vld  in  1  operand pair valid
- op_rdy  out  1  FIFO not full
- op_a, op_b  in  16  operands
- res_vld  out  1  result valid
- res_rdy  in  1  result consumed when res_vld & res_rdy
- res_c  out  16  captured accumulator
- mac_a, mac_b  out  16  operands to MAC
- mac_en  out  1  MAC enable, high from CFG through WAIT
- mac_vld  out  1  MAC input strobe
- mac_rd  out  1  result read pulse
- mac_mode  out  1  mode, held for whole job
- mac_cfg  out  1  config pulse: clears accumulator, latches mode
- mac_c  in  16  MAC result
- busy  out  1  state != IDLE

## Operation
- MAC contract: mac_vld & mac_cfg clears the accumulator and sets mode. mac_vld & !mac_cfg accumulates mac_a*mac_b. mac_c is valid exactly RD_LAT cycles after the mac_rd cycle.
- FIFO: push on op_vld & op_rdy in any state. op_rdy = !full, with no push-while-full bypass. Pop only in RUN on issue. Operands belong to jobs in arrival order.
- FSM states IDLE, CFG, RUN, READ, WAIT, HOLD:
  - IDLE: job_rdy = 1. On handshake, latch job_mode/job_len, clear count, go to CFG.
  - CFG (1 cycle): mac_cfg = mac_vld = 1, mac_a = mac_b = 0. Go to RUN if len ≠ 0, else READ.
  - RUN: when FIFO is non-empty, mac_vld = 1 with the head pair, pop, and count+1. When FIFO is empty, mac_vld = 0 and count holds. After the issue that makes count == len, go to READ.
  - READ (1 cycle): mac_rd = 1, then WAIT.
  - WAIT: count RD_LAT cycles. In the cycle RD_LAT after READ, capture mac_c into res_c and go to HOLD.
  - HOLD: res_vld = 1. res_c stays stable until res_rdy; then go to IDLE.
- Whenever mac_vld = 0, mac_a and mac_b are driven to 0.
- count is LEN_W bits and never wraps, because the compare to len precedes the increment.
- Reset (any state): state goes to IDLE, the FIFO is flushed, and any in-flight job is dropped with no result.

## Timing
- All outputs are registered except op_rdy and job_rdy, which are registered-state decodes.
- Reset values: every output is 0, including op_rdy, which rises in the first cycle after rst deasserts.
- Job handshake at cycle T:
  - mac_cfg at T+1.
  - With the FIFO prefilled, operands at T+2..T+1+N.
  - mac_rd at T+2+N.
  - Capture at T+2+N+RD_LAT.
  - res_vld from T+3+N+RD_LAT.
- Each FIFO-empty cycle in RUN adds one cycle to everything after it.
- job_len = 0: mac_rd at T+2, res_vld at T+3+RD_LAT.
- Back-to-back: the earliest next job handshake is the cycle after the res handshake (job_rdy rises then).
- Simultaneous push and pop in RUN: both occur and occupancy is unchanged. When full, op_rdy is low even if a pop occurs that cycle.

## Structure
- mac_pkg holds:
  - DATA_W = 16
  - MODE_INT = 1'b0, MODE_FP = 1'b1
  - the state enum issue_state_e
- Sub-module mac_op_fifo(DEPTH, width 32): synchronous FIFO with full/empty flags and the same clk/rst. The FSM and counters live in mac_issue_ctrl.

## Test plan
- INT job, len = 3, FIFO prefilled with (2,3),(4,5),(1,7), MAC model RD_LAT = 2. Expected:
  - mac_cfg at T+1, mac_vld at T+1..T+4, mac_rd at T+5.
  - res_vld at T+8 with res_c = 33 (0x0021), mode = 0 throughout.
- FP job, len = 2, with op_vld gapped 2 cycles between pairs:
  - mac_vld drops during the gaps and count holds.
  - mac_rd comes exactly one cycle after the second issue.
  - mac_mode = 1 for the whole job.
- DEPTH = 4, push 5 pairs in IDLE:
  - op_rdy goes low after the 4th push.
  - The 5th pair is accepted only after the first RUN pop.
  - Pop order is FIFO.
- res_rdy held low for 5 cycles in HOLD:
  - res_vld and res_c stay stable, job_rdy stays 0, busy stays 1.
  - Releasing res_rdy gives job_rdy = 1 the next cycle.
- rst asserted mid-RUN after 1 of 3 issues:
  - The next cycle all outputs are 0 and the FIFO is empty.
  - No res_vld appears.
  - A new job then runs normally.
- job_len = 0: CFG, then READ at T+2, with no non-cfg mac_vld; res_c equals the model's cleared value 0.
